// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared types for the memory copy/fill engine
//
// Purpose: state and mode encodings used by mem_copy_engine.
// Ports:   none (package).

package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_t;

endpackage

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - bus-master block copy / block fill sequencer
//
// Purpose: drives a single-port memory (combinational read, write on the
// rising edge that ends a write cycle) to copy or fill a block of bytes
// while the core is held off the port by an external mux keyed on busy_o.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              job request, sampled only while idle
//   mode_i               0 = copy, 1 = fill
//   src_addr_i           copy source base (unused for fill)
//   dst_addr_i           destination base
//   len_i                byte count, 0 .. 2**A
//   fill_val_i           fill constant
//   mem_data_i           memory read data for mem_addr_o
//   mem_addr_o           memory address
//   mem_wr_en_o          memory write enable
//   mem_wr_data_o        memory write data
//   busy_o               engine owns the memory port
//   done_o               one-cycle completion pulse

module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [A-1:0] src_addr_i,
  input  logic [A-1:0] dst_addr_i,
  input  logic [A:0]   len_i,
  input  logic [W-1:0] fill_val_i,
  input  logic [W-1:0] mem_data_i,
  output logic [A-1:0] mem_addr_o,
  output logic         mem_wr_en_o,
  output logic [W-1:0] mem_wr_data_o,
  output logic         busy_o,
  output logic         done_o
);

  state_t       state_q, state_d;
  mode_t        mode_q, mode_d;
  logic         desc_q, desc_d;
  logic [A-1:0] src_ptr_q, src_ptr_d;
  logic [A-1:0] dst_ptr_q, dst_ptr_d;
  logic [A:0]   rem_q, rem_d;
  logic [W-1:0] buf_q, buf_d;
  logic [W-1:0] fill_q, fill_d;

  logic         start_desc;
  logic [A-1:0] len_m1;

  // An overlapping copy toward higher addresses must run from the top end
  // down, otherwise it overwrites source bytes before reading them.
  assign start_desc = (mode_i == MODE_COPY) && (dst_addr_i > src_addr_i);
  // Truncation to A bits is intended: Len = 2**A gives an offset of 2**A-1.
  assign len_m1     = len_i[A-1:0] - A'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mode_q    <= MODE_COPY;
      desc_q    <= 1'b0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      buf_q     <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      desc_q    <= desc_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    desc_d    = desc_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    buf_d     = buf_q;
    fill_d    = fill_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d = mode_t'(mode_i);
          fill_d = fill_val_i;
          rem_d  = len_i;
          desc_d = start_desc;
          if (start_desc) begin
            src_ptr_d = src_addr_i + len_m1;
            dst_ptr_d = dst_addr_i + len_m1;
          end else begin
            src_ptr_d = src_addr_i;
            dst_ptr_d = dst_addr_i;
          end
          if (len_i == '0) begin
            state_d = DONE;
          end else if (mode_t'(mode_i) == MODE_FILL) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        buf_d   = mem_data_i;
        state_d = WRITE;
      end

      WRITE: begin
        rem_d = rem_q - (A+1)'(1);
        if (desc_q) begin
          src_ptr_d = src_ptr_q - A'(1);
          dst_ptr_d = dst_ptr_q - A'(1);
        end else begin
          src_ptr_d = src_ptr_q + A'(1);
          dst_ptr_d = dst_ptr_q + A'(1);
        end
        if (rem_q == (A+1)'(1)) begin
          state_d = DONE;
        end else if (mode_q == MODE_FILL) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs depend only on registers, so reset clears them without waiting
  // for a clock edge and no partial write can leak out.
  always_comb begin
    mem_addr_o    = '0;
    mem_wr_en_o   = 1'b0;
    mem_wr_data_o = '0;
    busy_o        = (state_q != IDLE);
    done_o        = (state_q == DONE);
    unique case (state_q)
      READ: begin
        mem_addr_o = src_ptr_q;
      end
      WRITE: begin
        mem_addr_o    = dst_ptr_q;
        mem_wr_en_o   = 1'b1;
        mem_wr_data_o = (mode_q == MODE_FILL) ? fill_q : buf_q;
      end
      default: begin
        mem_addr_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - self-checking bench for mem_copy_engine

module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [8:0] len;
  logic [7:0] fill_val;
  logic [7:0] mem_data;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       busy;
  logic       done;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_trace[$];
  logic [7:0] act_trace[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  mem_copy_engine #(.W(8), .A(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .mode_i       (mode),
    .src_addr_i   (src_addr),
    .dst_addr_i   (dst_addr),
    .len_i        (len),
    .fill_val_i   (fill_val),
    .mem_data_i   (mem_data),
    .mem_addr_o   (mem_addr),
    .mem_wr_en_o  (mem_wr_en),
    .mem_wr_data_o(mem_wr_data),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Reference: apply the job byte by byte in the order the rules dictate,
  // recording the address sequence the memory port should show.
  task automatic model(input bit m, input logic [7:0] s0, input logic [7:0] d0,
                       input int n, input logic [7:0] fv);
    logic [7:0] s, d;
    bit desc;
    exp_trace.delete();
    desc = (m == 1'b0) && (d0 > s0);
    s = desc ? 8'(s0 + n - 1) : s0;
    d = desc ? 8'(d0 + n - 1) : d0;
    for (int i = 0; i < n; i++) begin
      if (m == 1'b0) begin
        exp_trace.push_back(s);
        exp_trace.push_back(d);
        ref_mem[d] = ref_mem[s];
      end else begin
        exp_trace.push_back(d);
        ref_mem[d] = fv;
      end
      s = desc ? s - 8'd1 : s + 8'd1;
      d = desc ? d - 8'd1 : d + 8'd1;
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s memory: %0d bytes differ, required 0", name, bad);
    end
  endtask

  // Must be called right after a falling edge. Drives the job, follows it to
  // completion and checks timing, write count, address trace and memory.
  task automatic run_job(input string name, input bit m, input logic [7:0] s0,
                         input logic [7:0] d0, input int n, input logic [7:0] fv,
                         input int restart_at, input bit tight);
    int exp_done, last, done_cyc, n_done, n_wr, busy_bad, trace_bad;
    model(m, s0, d0, n, fv);
    act_trace.delete();
    exp_done = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
    last     = tight ? exp_done + 1 : exp_done + 2;
    done_cyc = -1; n_done = 0; n_wr = 0; busy_bad = 0;
    mode = m; src_addr = s0; dst_addr = d0; len = 9'(n); fill_val = fv;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start    = 1'b0;
        mode     = 1'($urandom);
        src_addr = 8'($urandom);
        dst_addr = 8'($urandom);
        len      = 9'($urandom);
        fill_val = 8'($urandom);
      end
      if (restart_at != 0 && c == restart_at) begin
        start = 1'b1; mode = m; src_addr = s0; dst_addr = d0 + 8'h33; len = 9'(n);
      end
      if (restart_at != 0 && c == restart_at + 1) start = 1'b0;
      if (mem_wr_en) begin
        mem[mem_addr] = mem_wr_data;
        n_wr++;
      end
      if (busy && !done) act_trace.push_back(mem_addr);
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (busy !== (c <= exp_done)) busy_bad++;
    end
    checks++;
    if (done_cyc != exp_done) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_done);
    end
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d required 1", name, n_done);
    end
    checks++;
    if (n_wr != n) begin
      failures++;
      $display("FAIL %s write_count: got %0d required %0d", name, n_wr, n);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL %s busy_window: %0d wrong cycles, required 0", name, busy_bad);
    end
    trace_bad = (act_trace.size() != exp_trace.size()) ? 1 : 0;
    if (trace_bad == 0)
      for (int i = 0; i < exp_trace.size(); i++)
        if (act_trace[i] !== exp_trace[i]) trace_bad++;
    checks++;
    if (trace_bad != 0) begin
      failures++;
      $display("FAIL %s addr_trace: %0d entries of %0d differ (len got %0d required %0d)",
               name, trace_bad, exp_trace.size(), act_trace.size(), exp_trace.size());
    end
    check_mem(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_val = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #1;
    checks++;
    if ({mem_addr, mem_wr_en, mem_wr_data, busy, done} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: got addr=%h we=%b wd=%h busy=%b done=%b required all 0",
               mem_addr, mem_wr_en, mem_wr_data, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b we=%b required 0 0", busy, mem_wr_en);
    end
  endtask

  task automatic test_copy_basic();
    logic [7:0] v[4];
    v[0] = 8'd11; v[1] = 8'd22; v[2] = 8'd33; v[3] = 8'd44;
    for (int i = 0; i < 4; i++) begin
      mem[8'h10 + i] = v[i]; ref_mem[8'h10 + i] = v[i];
    end
    run_job("copy_basic", 1'b0, 8'h10, 8'h40, 4, 8'h00, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h40 + i] !== v[i]) begin
        failures++;
        $display("FAIL copy_basic byte%0d: got %0d required %0d", i, mem[8'h40 + i], v[i]);
      end
    end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] keep;
    keep = mem[8'h01];
    run_job("fill_wrap", 1'b1, 8'h00, 8'hFE, 3, 8'hA5, 0, 1'b0);
    checks++;
    if (mem[8'hFE] !== 8'hA5 || mem[8'hFF] !== 8'hA5 || mem[8'h00] !== 8'hA5) begin
      failures++;
      $display("FAIL fill_wrap bytes: got %h %h %h required a5 a5 a5",
               mem[8'hFE], mem[8'hFF], mem[8'h00]);
    end
    checks++;
    if (mem[8'h01] !== keep) begin
      failures++;
      $display("FAIL fill_wrap untouched: got %h required %h", mem[8'h01], keep);
    end
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 4; i++) begin
      mem[8'h20 + i] = 8'(i + 1); ref_mem[8'h20 + i] = 8'(i + 1);
    end
    run_job("overlap", 1'b0, 8'h20, 8'h21, 4, 8'h00, 0, 1'b0);
    checks++;
    if (act_trace.size() < 4 || act_trace[0] !== 8'h23 || act_trace[1] !== 8'h24 ||
        act_trace[2] !== 8'h22 || act_trace[3] !== 8'h23) begin
      failures++;
      $display("FAIL overlap first_addrs: trace size %0d, required 23 24 22 23 leading", act_trace.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h21 + i] !== 8'(i + 1)) begin
        failures++;
        $display("FAIL overlap byte%0d: got %0d required %0d", i, mem[8'h21 + i], i + 1);
      end
    end
  endtask

  task automatic test_len_zero();
    run_job("len_zero", 1'b0, 8'h55, 8'h66, 0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_reset_mid_job();
    logic [7:0] s0, d0;
    s0 = 8'h80; d0 = 8'h60;
    mode = 1'b0; src_addr = s0; dst_addr = d0; len = 9'd8; fill_val = 8'h00;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c < 6) begin
        if (mem_wr_en) mem[mem_addr] = mem_wr_data;
      end else begin
        checks++;
        if (mem_wr_en !== 1'b1 || mem_addr !== d0 + 8'd2) begin
          failures++;
          $display("FAIL reset_mid third_write: got we=%b addr=%h required 1 %h",
                   mem_wr_en, mem_addr, d0 + 8'd2);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            mem_addr !== 8'h00 || mem_wr_data !== 8'h00) begin
          failures++;
          $display("FAIL reset_mid outputs: got we=%b busy=%b done=%b addr=%h wd=%h required all 0",
                   mem_wr_en, busy, done, mem_addr, mem_wr_data);
        end
      end
    end
    ref_mem[d0]        = ref_mem[s0];
    ref_mem[d0 + 8'd1] = ref_mem[s0 + 8'd1];
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid held: got busy=%b we=%b required 0 0", busy, mem_wr_en);
    end
    check_mem("reset_mid");
    rst_n = 1'b1;
    @(negedge clk);
    run_job("after_reset", 1'b0, 8'h90, 8'hC0, 5, 8'h00, 0, 1'b0);
  endtask

  task automatic test_restart_ignored();
    run_job("restart_ignored", 1'b0, 8'h30, 8'hB0, 6, 8'h00, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", 1'b1, 8'h00, 8'h70, 5, 8'h3C, 0, 1'b1);
    run_job("b2b_b", 1'b0, 8'h70, 8'h78, 5, 8'h00, 0, 1'b1);
    run_job("b2b_c", 1'b0, 8'h78, 8'h74, 5, 8'h00, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      run_job($sformatf("random%0d", j), 1'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 24)), 8'($urandom), 0, 1'($urandom));
    end
    run_job("fill_full", 1'b1, 8'h00, 8'h9A, 256, 8'h5E, 0, 1'b0);
    run_job("copy_full_desc", 1'b0, 8'h10, 8'h20, 256, 8'h00, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_copy_basic();
    test_fill_wrap();
    test_overlap();
    test_len_zero();
    test_reset_mid_job();
    test_restart_ignored();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
